// File: rtl/digit_scan_sequencer.sv
// digit_scan_sequencer
// Walks a latched WIDTH-bit value out through one 7-segment digit, one hex
// nibble at a time, MSB nibble first. Each digit is shown for HOLD_CYCLES
// and followed by GAP_CYCLES of forced blanking. The decimal point marks the
// least-significant digit, and done pulses once after the last gap.
module digit_scan_sequencer #(
   parameter int WIDTH       = 16,
   parameter int HOLD_CYCLES = 1000,
   parameter int GAP_CYCLES  = 250,
   parameter int SUPPRESS_LZ = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic [3:0]       nibble,
   output logic             blank,
   output logic             dp,
   output logic             busy,
   output logic             done
);

   localparam int NDIG = WIDTH / 4;
   localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNTW = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_CYCLES - 1);
   localparam logic [CNTW-1:0] GAP_LAST  = CNTW'(GAP_CYCLES - 1);
   localparam logic [IDXW-1:0] IDX_TOP   = IDXW'(NDIG - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t           r_state, w_state_next;
   logic [WIDTH-1:0] r_value, w_value_next;
   logic [IDXW-1:0]  r_idx,   w_idx_next;
   logic [CNTW-1:0]  r_cnt,   w_cnt_next;

   logic [3:0]       r_nibble, w_nibble_next;
   logic             r_blank,  w_blank_next;
   logic             r_dp,     w_dp_next;
   logic             r_busy,   w_busy_next;
   logic             r_done,   w_done_next;

   logic [NDIG-1:0]  w_nz;
   logic [IDXW-1:0]  w_lead_idx;
   logic [IDXW-1:0]  w_first_idx;
   logic             w_gap_end;

   // Per-nibble nonzero flags of the incoming value
   genvar gi;
   generate
      for (gi = 0; gi < NDIG; gi++) begin : g_nz
         assign w_nz[gi] = |value[4*gi +: 4];
      end
   endgenerate

   // Highest nonzero nibble index; a zero value falls back to nibble 0
   always_comb begin
      w_lead_idx = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (w_nz[i]) w_lead_idx = IDXW'(i);
      end
   end

   assign w_first_idx = (SUPPRESS_LZ != 0) ? w_lead_idx : IDX_TOP;
   assign w_gap_end   = (r_state == ST_GAP) && (r_cnt == GAP_LAST);

   // State, latched value, digit index, phase counter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_value  <= '0;
         r_idx    <= '0;
         r_cnt    <= '0;
         r_nibble <= 4'h0;
         r_blank  <= 1'b1;
         r_dp     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_value  <= w_value_next;
         r_idx    <= w_idx_next;
         r_cnt    <= w_cnt_next;
         r_nibble <= w_nibble_next;
         r_blank  <= w_blank_next;
         r_dp     <= w_dp_next;
         r_busy   <= w_busy_next;
         r_done   <= w_done_next;
      end
   end

   // Next-state: a load always restarts; otherwise step through SHOW/GAP phases
   always_comb begin
      w_state_next = r_state;
      w_value_next = r_value;
      w_idx_next   = r_idx;
      w_cnt_next   = r_cnt;
      if (load) begin
         w_state_next = ST_SHOW;
         w_value_next = value;
         w_idx_next   = w_first_idx;
         w_cnt_next   = '0;
      end else begin
         case (r_state)
            ST_SHOW: begin
               if (r_cnt == HOLD_LAST) begin
                  w_state_next = ST_GAP;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt + CNTW'(1);
               end
            end
            ST_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  w_cnt_next = '0;
                  if (r_idx != '0) begin
                     w_idx_next   = r_idx - IDXW'(1);
                     w_state_next = ST_SHOW;
                  end else begin
                     w_state_next = ST_IDLE;
                  end
               end else begin
                  w_cnt_next = r_cnt + CNTW'(1);
               end
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decoded from the upcoming state so they register alongside it
   always_comb begin
      w_nibble_next = w_value_next[{w_idx_next, 2'b00} +: 4];
      w_blank_next  = 1'b1;
      w_dp_next     = 1'b0;
      w_busy_next   = 1'b1;
      w_done_next   = w_gap_end && (r_idx == '0) && !load;
      case (w_state_next)
         ST_SHOW: begin
            w_blank_next = 1'b0;
            w_dp_next    = (w_idx_next == '0);
         end
         ST_GAP: begin
            w_blank_next = 1'b1;
         end
         default: begin
            w_nibble_next = 4'h0;
            w_busy_next   = 1'b0;
         end
      endcase
   end

   assign nibble = r_nibble;
   assign blank  = r_blank;
   assign dp     = r_dp;
   assign busy   = r_busy;
   assign done   = r_done;

endmodule
